// File: rtl/mio_bus_bridge_if.sv
// CPU data-side bus between the MEM stage and the memory/IO bridge.
interface mio_bus_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        MIO_ready;
  logic        bus_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, MIO_ready, bus_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, MIO_ready, bus_err
  );
endinterface

// File: rtl/mio_bus_bridge.sv
// Memory/IO bridge: steers CPU loads/stores to the data RAM or to the LED,
// switch and timer registers, and stalls the pipeline during RAM reads.
//
// state | meaning
// IDLE  | decode request; everything except a RAM load completes here
// WAIT  | RAM load in flight, wcnt counts the remaining latency
// DONE  | ram_rdata valid, load completes, back to IDLE without re-decode
module mio_bus_bridge #(
  parameter int RAM_AW      = 10,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  mio_bus_bridge_if.slave   bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic              timer_irq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state, stateNext;
  logic [3:0]  wcnt, wcntNext;
  logic        ramHit, ioHit, unmapped, inIdle, ramLoad, ioWr;
  logic [1:0]  ioReg;
  logic [31:0] ioRdata;
  logic [15:0] ledReg, swMeta, swSync;
  logic [31:0] counter, compare;
  logic        irqReg, busErrReg;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^bus.cpu_addr[1:0];

  // RAM hit needs every bit above the word address clear, which also covers [31:28]=0
  assign ramHit   = bus.cpu_req && (bus.cpu_addr[31:RAM_AW+2] == '0);
  assign ioHit    = bus.cpu_req && (bus.cpu_addr[31:4] == 28'hF00_0000);
  assign unmapped = bus.cpu_req && !ramHit && !ioHit;
  assign inIdle   = (state == IDLE);
  assign ramLoad  = inIdle && ramHit && !bus.cpu_we;
  assign ioWr     = inIdle && ioHit && bus.cpu_we;
  assign ioReg    = bus.cpu_addr[3:2];

  assign ram_addr  = bus.cpu_addr[RAM_AW+1:2];
  assign ram_wdata = bus.cpu_wdata;
  assign ram_we    = inIdle && ramHit && bus.cpu_we;

  assign led_out     = ledReg;
  assign timer_irq   = irqReg;
  assign bus.bus_err = busErrReg;

  always_comb begin
    stateNext = state;
    wcntNext  = wcnt;
    case (state)
      IDLE: begin
        if (ramLoad) begin
          if (RAM_LATENCY == 1) begin
            stateNext = DONE;
          end else begin
            stateNext = WAIT;
            wcntNext  = 4'(RAM_LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (wcnt == 4'd0) stateNext = DONE;
        else              wcntNext  = wcnt - 4'd1;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    case (ioReg)
      2'd0:    ioRdata = {16'h0000, ledReg};
      2'd1:    ioRdata = {16'h0000, swSync};
      2'd2:    ioRdata = counter;
      default: ioRdata = compare;
    endcase
  end

  always_comb begin
    bus.MIO_ready = 1'b1;
    bus.cpu_rdata = 32'h0;
    case (state)
      IDLE: begin
        if (ramLoad)                    bus.MIO_ready = 1'b0;
        else if (ioHit && !bus.cpu_we)  bus.cpu_rdata = ioRdata;
      end
      WAIT:    bus.MIO_ready = 1'b0;
      DONE:    bus.cpu_rdata = ram_rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= stateNext;
      wcnt  <= wcntNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ledReg    <= 16'h0;
      swMeta    <= 16'h0;
      swSync    <= 16'h0;
      counter   <= 32'h0;
      compare   <= 32'hFFFF_FFFF;
      irqReg    <= 1'b0;
      busErrReg <= 1'b0;
    end else begin
      swMeta    <= sw_in;
      swSync    <= swMeta;
      busErrReg <= inIdle && unmapped;
      if (ioWr && ioReg == 2'd0) ledReg <= bus.cpu_wdata[15:0];
      if (ioWr && ioReg == 2'd2) counter <= bus.cpu_wdata;
      else                       counter <= counter + 32'd1;
      // a compare write clears the flag even if this edge is also a match
      if (ioWr && ioReg == 2'd3) begin
        compare <= bus.cpu_wdata;
        irqReg  <= 1'b0;
      end else if (counter == compare) begin
        irqReg  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Bench for mio_bus_bridge: one instance at RAM_LATENCY=1 for the short
// directed load/store, one at RAM_LATENCY=3 for everything else.
module tb_mio_bus_bridge;
  localparam int AW   = 10;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0, l1Sel = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [15:0] sw = 16'h0;
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mio_bus_bridge_if bus1();
  mio_bus_bridge_if bus3();
  assign bus1.cpu_req   = req & l1Sel;
  assign bus3.cpu_req   = req & ~l1Sel;
  assign bus1.cpu_we    = we;
  assign bus3.cpu_we    = we;
  assign bus1.cpu_addr  = addr;
  assign bus3.cpu_addr  = addr;
  assign bus1.cpu_wdata = wdata;
  assign bus3.cpu_wdata = wdata;

  logic [AW-1:0] ramAddr1, ramAddr3;
  logic          ramWe1, ramWe3, irq1, irq3;
  logic [31:0]   ramWdata1, ramWdata3, ramRdata1, ramRdata3;
  logic [15:0]   led1, led3;

  mio_bus_bridge #(.RAM_AW(AW), .RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .ram_addr(ramAddr1), .ram_we(ramWe1), .ram_wdata(ramWdata1), .ram_rdata(ramRdata1),
    .sw_in(sw), .led_out(led1), .timer_irq(irq1));

  mio_bus_bridge #(.RAM_AW(AW), .RAM_LATENCY(LAT3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave),
    .ram_addr(ramAddr3), .ram_we(ramWe3), .ram_wdata(ramWdata3), .ram_rdata(ramRdata3),
    .sw_in(sw), .led_out(led3), .timer_irq(irq3));

  // RAM models: read data appears RAM_LATENCY cycles after the address
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    if (ramWe1) mem1[ramAddr1] <= ramWdata1;
    pipe1 <= mem1[ramAddr1];
    if (ramWe3) mem3[ramAddr3] <= ramWdata3;
    pipe3[0] <= mem3[ramAddr3];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ramRdata1 = pipe1;
  assign ramRdata3 = pipe3[2];

  logic          oReady, oBusErr, oRamWe, oIrq;
  logic [31:0]   oRdata, oRamWdata;
  logic [AW-1:0] oRamAddr;
  logic [15:0]   oLed;
  assign oReady    = l1Sel ? bus1.MIO_ready : bus3.MIO_ready;
  assign oBusErr   = l1Sel ? bus1.bus_err   : bus3.bus_err;
  assign oRdata    = l1Sel ? bus1.cpu_rdata : bus3.cpu_rdata;
  assign oRamWe    = l1Sel ? ramWe1    : ramWe3;
  assign oRamWdata = l1Sel ? ramWdata1 : ramWdata3;
  assign oRamAddr  = l1Sel ? ramAddr1  : ramAddr3;
  assign oLed      = l1Sel ? led1      : led3;
  assign oIrq      = l1Sel ? irq1      : irq3;

  // Reference model for the latency-3 instance; counter kept as base + elapsed cycles
  logic [15:0] mLed;
  logic [31:0] mCmp, mBase;
  int          mBaseCyc;
  logic        mIrq;
  logic [31:0] mMem [1024];
  bit          mWritten [1024];
  logic [15:0] swPrev = 16'h0, swNow = 16'h0;
  int          swCyc = 0;
  logic        ioWrM;
  assign ioWrM = bus3.cpu_req && we && (addr[31:4] == 28'hF00_0000);

  function automatic logic [31:0] cntAt(input int k);
    return mBase + 32'(k - mBaseCyc);
  endfunction

  function automatic logic [15:0] swExp();
    return (cyc >= swCyc + 2) ? swNow : swPrev;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mLed <= 16'h0; mCmp <= 32'hFFFF_FFFF; mIrq <= 1'b0;
      mBase <= 32'h0; mBaseCyc <= cyc + 1;
    end else begin
      if (ioWrM && addr[3:2] == 2'd0) mLed <= wdata[15:0];
      if (ioWrM && addr[3:2] == 2'd2) begin mBase <= wdata; mBaseCyc <= cyc + 1; end
      if (ioWrM && addr[3:2] == 2'd3) begin mCmp <= wdata; mIrq <= 1'b0; end
      else if (cntAt(cyc) == mCmp) mIrq <= 1'b1;
    end
  end

  int checks = 0, errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // starts and ends at posedge+1; holds the request until MIO_ready
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int expWaits, output logic [31:0] rd);
    int   n;
    logic expWe;
    expWe = w && (a < (32'd4 << AW));
    req = 1'b1; we = w; addr = a; wdata = d;
    n = 0;
    @(negedge clk);
    while (!oReady && n < 20) begin n++; @(negedge clk); end
    checkVal("waitStates", 32'(n), 32'(expWaits));
    rd = oRdata;
    checkVal("ramWe", {31'b0, oRamWe}, {31'b0, expWe});
    if (expWe) begin
      checkVal("ramAddr", {22'b0, oRamAddr}, {22'b0, a[11:2]});
      checkVal("ramWdata", oRamWdata, d);
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic idleCheck(input logic expErr);
    @(negedge clk);
    checkVal("idleReady", {31'b0, oReady}, 32'd1);
    checkVal("idleRdata", oRdata, 32'h0);
    checkVal("idleRamWe", {31'b0, oRamWe}, 32'd0);
    checkVal("busErr", {31'b0, oBusErr}, {31'b0, expErr});
    if (!l1Sel) begin
      checkVal("led", {16'b0, oLed}, {16'b0, mLed});
      checkVal("irq", {31'b0, oIrq}, {31'b0, mIrq});
    end
    @(posedge clk); #1;
  endtask

  function automatic int pickWord();
    return ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] pickUnmapped();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_1000;
      1:       return 32'h8000_0000;
      2:       return 32'hF000_0010;
      3:       return 32'h0FFF_FFFC;
      default: return {4'($urandom_range(1, 14)), 28'($urandom)};
    endcase
  endfunction

  function automatic logic [31:0] ioExp(input int r);
    case (r)
      0:       return {16'h0, mLed};
      1:       return {16'h0, swExp()};
      2:       return cntAt(cyc);
      default: return mCmp;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, d, a, e;
    logic        w, err;
    int          wi, kind, r, n;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; swPrev = 16'h0; swCyc = cyc;

    // reset state
    @(negedge clk);
    checkVal("rstReady", {31'b0, oReady}, 32'd1);
    checkVal("rstRdata", oRdata, 32'h0);
    checkVal("rstBusErr", {31'b0, oBusErr}, 32'd0);
    checkVal("rstLed", {16'b0, oLed}, 32'h0);
    checkVal("rstIrq", {31'b0, oIrq}, 32'd0);
    @(posedge clk); #1;
    access(1'b0, 32'hF000_000C, 32'h0, 0, rd);
    checkVal("rstCompare", rd, 32'hFFFF_FFFF);
    idleCheck(1'b0);

    // RAM_LATENCY=1 store then load
    l1Sel = 1'b1;
    access(1'b1, 32'h10, 32'h1234_5678, 0, rd);
    idleCheck(1'b0);
    access(1'b0, 32'h10, 32'h0, 1, rd);
    checkVal("l1Load", rd, 32'h1234_5678);
    idleCheck(1'b0);
    l1Sel = 1'b0;

    // RAM_LATENCY=3 load held for the full access
    access(1'b1, 32'h20, 32'hA5A5_0F0F, 0, rd);
    mMem[8] = 32'hA5A5_0F0F; mWritten[8] = 1'b1;
    idleCheck(1'b0);
    access(1'b0, 32'h20, 32'h0, LAT3, rd);
    checkVal("l3Load", rd, 32'hA5A5_0F0F);
    idleCheck(1'b0);

    // LED and switches
    access(1'b1, 32'hF000_0000, 32'h0000_ABCD, 0, rd);
    idleCheck(1'b0);
    checkVal("ledWrite", {16'b0, oLed}, 32'h0000_ABCD);
    sw = 16'h00F0; swPrev = swNow; swNow = sw; swCyc = cyc;
    for (int i = 0; i < 3; i++) begin
      e = {16'h0, swExp()};
      access(1'b0, 32'hF000_0004, 32'h0, 0, rd);
      checkVal("swRead", rd, e);
    end
    checkVal("swSettled", rd, 32'h0000_00F0);
    idleCheck(1'b0);

    // unmapped read and write to a read-only register
    access(1'b0, 32'h8000_0000, 32'h0, 0, rd);
    checkVal("unmapRd", rd, 32'h0);
    idleCheck(1'b1);
    idleCheck(1'b0);
    access(1'b1, 32'hF000_0004, 32'h0000_FFFF, 0, rd);
    idleCheck(1'b0);
    access(1'b0, 32'hF000_0004, 32'h0, 0, rd);
    checkVal("swRoWrite", rd, 32'h0000_00F0);
    checkVal("ledKept", {16'b0, oLed}, 32'h0000_ABCD);
    idleCheck(1'b0);

    // timer compare: irq rises when the counter reaches 20
    access(1'b1, 32'hF000_000C, 32'd20, 0, rd);
    access(1'b1, 32'hF000_0008, 32'd0, 0, rd);
    n = 0;
    @(negedge clk);
    while (!oIrq && n < 40) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    checkVal("irqRise", 32'(n), 32'd21);
    idleCheck(1'b0);
    // compare written on the match edge: clear wins
    access(1'b1, 32'hF000_000C, 32'd20, 0, rd);
    access(1'b1, 32'hF000_0008, 32'd0, 0, rd);
    repeat (20) @(posedge clk);
    #1;
    access(1'b1, 32'hF000_000C, 32'h0000_0500, 0, rd);
    @(negedge clk);
    checkVal("irqClearWins", {31'b0, oIrq}, 32'd0);
    @(posedge clk); #1;
    idleCheck(1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 8);
      err  = 1'b0;
      case (kind)
        0, 1, 2: begin
          wi = pickWord(); d = $urandom;
          access(1'b1, 32'(wi) << 2, d, 0, rd);
          mMem[wi] = d; mWritten[wi] = 1'b1;
        end
        3, 4: begin
          wi = pickWord();
          if (mWritten[wi]) begin
            access(1'b0, 32'(wi) << 2, 32'h0, LAT3, rd);
            checkVal("ramLoad", rd, mMem[wi]);
          end
        end
        5: begin
          r = $urandom_range(0, 3);
          a = 32'hF000_0000 | (32'(r) << 2) | 32'($urandom_range(0, 3));
          e = ioExp(r);
          access(1'b0, a, 32'h0, 0, rd);
          checkVal("ioRead", rd, e);
        end
        6: begin
          r = $urandom_range(0, 2);
          if (r != 0) r = r + 1;
          if (r == 3 && $urandom_range(0, 1) == 1) d = cntAt(cyc) + 32'($urandom_range(2, 10));
          else                                      d = $urandom;
          a = 32'hF000_0000 | (32'(r) << 2) | 32'($urandom_range(0, 3));
          access(1'b1, a, d, 0, rd);
        end
        7: begin
          a = pickUnmapped(); w = 1'($urandom_range(0, 1));
          access(w, a, $urandom, 0, rd);
          if (!w) checkVal("unmapRd", rd, 32'h0);
          err = 1'b1;
        end
        default: begin
          sw = 16'($urandom); swPrev = swNow; swNow = sw; swCyc = cyc;
          e = {16'h0, swExp()};
          access(1'b0, 32'hF000_0004, 32'h0, 0, rd);
          checkVal("swChange", rd, e);
        end
      endcase
      idleCheck(err);
    end

    // reset while a RAM load waits
    access(1'b1, 32'h40, 32'hCAFE_F00D, 0, rd);
    mMem[16] = 32'hCAFE_F00D; mWritten[16] = 1'b1;
    idleCheck(1'b0);
    req = 1'b1; we = 1'b0; addr = 32'h40;
    @(negedge clk);
    checkVal("waitBeforeRst", {31'b0, oReady}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checkVal("rstRamWe", {31'b0, oRamWe}, 32'd0);
    checkVal("rstReadyHeld", {31'b0, oReady}, 32'd0);
    req = 1'b0; #1;
    checkVal("rstIdle", {31'b0, oReady}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; swPrev = 16'h0; swCyc = cyc;
    idleCheck(1'b0);
    checkVal("ledAfterRst", {16'b0, oLed}, 32'h0);
    access(1'b0, 32'h40, 32'h0, LAT3, rd);
    checkVal("loadAfterRst", rd, 32'hCAFE_F00D);
    idleCheck(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_bus_bridge.md
# mio_bus_bridge

Memory/IO bus bridge that sits directly downstream of the pipelined CPU's MEM stage. It consumes the CPU's data-side request (address, store data, write strobe) and steers it to the data RAM or to on-chip peripherals. Peripherals are an LED register, synchronized switches, and a timer with compare interrupt. It returns read data and the `MIO_ready` handshake that stalls the pipeline during multi-cycle RAM reads.

## Interface
Parameters:
- `RAM_AW`, 10: RAM word-address width; RAM occupies byte range 0x0000_0000 to (4·2^RAM_AW − 1).
- `RAM_LATENCY`, 1: RAM read latency in cycles, from address to valid `ram_rdata`; legal range 1..15.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: load/store request valid this cycle.
- `cpu_we` in 1: 1 = store, 0 = load; meaningful only with `cpu_req`.
- `cpu_addr` in 32: byte address, word-aligned; bits [1:0] are ignored.
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data; valid when `MIO_ready`=1 for a load.
- `MIO_ready` out 1: 0 = CPU must hold the request and stall; 1 = the access completes this cycle.
- `bus_err` out 1: one-cycle pulse on an access to an unmapped address.
- `ram_addr` out RAM_AW: RAM word address, equal to `cpu_addr[RAM_AW+1:2]`.
- `ram_we` out 1: RAM write strobe.
- `ram_wdata` out 32: RAM write data, equal to `cpu_wdata`.
- `ram_rdata` in 32: RAM read data.
- `sw_in` in 16: asynchronous switch inputs.
- `led_out` out 16: LED register.
- `timer_irq` out 1: sticky timer-compare interrupt.

## Operation
Address decode:
- RAM when `cpu_addr[31:28]`=0 and the address is in range.
- IO when `cpu_addr[31:4]`=0xF000_000.
- Everything else is unmapped.

IO map:
- 0xF000_0000 LED: R/W; reads zero-extend bits [15:0]; writes take `cpu_wdata[15:0]`.
- 0xF000_0004 switches: read-only; `sw_in` passes through a 2-flop synchronizer; reads are zero-extended.
- 0xF000_0008 counter: read returns the current value; a write loads `cpu_wdata`.
- 0xF000_000C compare: R/W; a write also clears `timer_irq`.
- Writes to read-only or unmapped addresses are ignored.
- Unmapped reads return 0 and pulse `bus_err`. Unmapped writes also pulse `bus_err`.

State machine (IDLE, WAIT, DONE) for RAM loads only:
- IDLE with a RAM load:
  - `MIO_ready`=0.
  - Next state is DONE if RAM_LATENCY=1.
  - Otherwise next state is WAIT, with `wcnt` loaded to RAM_LATENCY−2.
- WAIT:
  - `MIO_ready`=0.
  - If `wcnt`=0, go to DONE; otherwise decrement `wcnt`.
- DONE:
  - `MIO_ready`=1 and `cpu_rdata`=`ram_rdata`.
  - Always return to IDLE. The request is not re-decoded, so there is no double issue.

All other accesses complete in IDLE in the same cycle with `MIO_ready`=1:
- RAM stores: `ram_we`=1 only in IDLE, with `cpu_req`&`cpu_we` and a RAM hit.
- IO reads and writes; IO read data is combinational.
- No request: `MIO_ready`=1 and `cpu_rdata`=0.

Timer:
- The 32-bit counter increments by 1 each cycle and wraps 0xFFFF_FFFF→0.
- A counter write in the same cycle wins over the increment.
- `timer_irq` sets on the edge where the counter value equals compare.
- If set and clear (compare write) occur in the same cycle, clear wins.

Reset values (asynchronous, on `rst`=0):
- State IDLE, `wcnt`=0, `led_out`=0, synchronizer flops 0.
- Counter 0, compare 0xFFFF_FFFF, `timer_irq`=0, `bus_err`=0.
- `MIO_ready` after reset follows the IDLE rule; it is 1 when there is no RAM-load request.
- Reset asserted during WAIT or DONE abandons the load. No RAM write results.

## Timing
- RAM load issued in cycle N (IDLE): `MIO_ready`=0 in cycles N..N+RAM_LATENCY−1, and `MIO_ready`=1 with data in cycle N+RAM_LATENCY. The next request is accepted in cycle N+RAM_LATENCY+1.
- RAM store, IO access, and unmapped access: zero wait states; `ram_we`/register update at the end of the request cycle.
- `bus_err`: registered; asserted in the cycle after the offending request, for 1 cycle.
- Switch path: a `sw_in` change is visible on a read 2–3 cycles later.
- `ram_addr` and `ram_wdata` are combinational from the CPU inputs. The CPU holds them stable while `MIO_ready`=0.

## Test plan
- RAM_LATENCY=1: store 0x1234_5678 to 0x10, then load 0x10. Required: the store shows `ram_we`=1 for 1 cycle with `ram_addr`=4. The load shows `MIO_ready` as 0 then 1, and `cpu_rdata`=0x1234_5678 in the second cycle.
- RAM_LATENCY=3: load held for the full access. Required: `MIO_ready`=0,0,0,1, single DONE, no second RAM access.
- LED/switch: write 0xABCD to 0xF000_0000 → `led_out`=0xABCD next cycle. Set `sw_in`=0x00F0 → a read of 0xF000_0004 returns 0x0000_00F0 within 3 cycles.
- Timer: write compare=20, write counter=0 → `timer_irq` rises when the counter reaches 20. A compare write on the same cycle as a match leaves `timer_irq`=0.
- Unmapped: read 0x8000_0000 → `cpu_rdata`=0, `MIO_ready`=1, `bus_err` pulses 1 cycle later. Write 0xF000_0004 → no state change.
- Reset in WAIT (RAM_LATENCY=3): assert `rst`=0 in cycle N+1 → immediate IDLE, `ram_we`=0. After release, a new load completes normally.
